// File: rtl/int_ctrl_if.sv
// Bus bundle between int_ctrl and the CPU core: interrupt sources, request/ack/return
// handshake, granted vector/id, service flag and the mask register port.
interface int_ctrl_if #(
  parameter int CHANNELS = 4,
  parameter int ADDR_W   = 16
);
  logic [CHANNELS-1:0] irq_in;
  logic                int_req;
  logic                int_ack;
  logic                int_ret;
  logic [ADDR_W-1:0]   int_vec;
  logic [3:0]          int_id;
  logic                busy;
  logic                mask_we;
  logic [CHANNELS-1:0] mask_wdata;
  logic [CHANNELS-1:0] mask_q;

  modport master (
    output irq_in, int_ack, int_ret, mask_we, mask_wdata,
    input  int_req, int_vec, int_id, busy, mask_q
  );

  modport slave (
    input  irq_in, int_ack, int_ret, mask_we, mask_wdata,
    output int_req, int_vec, int_id, busy, mask_q
  );
endinterface

// File: rtl/int_ctrl.sv
// Edge-triggered, non-nesting interrupt controller with fixed lowest-index priority.
// Define INT_MASK_EN to make the channel mask writable; otherwise it is fixed at all ones.
module int_ctrl #(
  parameter int CHANNELS   = 4,
  parameter int ADDR_W     = 16,
  parameter int TABLE_BASE = 34
) (
  input logic       clk,
  input logic       rst,
  int_ctrl_if.slave bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] SERVICE = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [CHANNELS-1:0] prev_q;
  logic [CHANNELS-1:0] pending_q, pending_d;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] grantable;
  logic [CHANNELS-1:0] clr;
  logic [CHANNELS-1:0] mask_q;
  logic [3:0]          id_q, id_d;
  logic [3:0]          win;
  logic                any;
  logic [ADDR_W-1:0]   vec_q, vec_d;

  assign rise      = bus.irq_in & ~prev_q;
  assign grantable = pending_q & mask_q;

  // Scanning from the top down lets the lowest enabled index overwrite the winner.
  always_comb begin
    win = 4'd0;
    any = 1'b0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (grantable[i]) begin
        win = 4'(i);
        any = 1'b1;
      end
    end
  end

  // Clearing is applied before the OR so a fresh edge on the acked channel survives.
  always_comb begin
    clr = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      clr[i] = (state_q == REQ) && bus.int_ack && (id_q == 4'(i));
    end
  end

  assign pending_d = (pending_q & ~clr) | rise;

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    vec_d   = vec_q;
    case (state_q)
      IDLE: begin
        if (any) begin
          state_d = REQ;
          id_d    = win;
          vec_d   = ADDR_W'(TABLE_BASE) + ADDR_W'(win);
        end
      end
      REQ: begin
        if (bus.int_ack) begin
          state_d = SERVICE;
        end
      end
      SERVICE: begin
        if (bus.int_ret) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      prev_q    <= '0;
      pending_q <= '0;
      id_q      <= 4'd0;
      vec_q     <= ADDR_W'(TABLE_BASE);
    end else begin
      state_q   <= state_d;
      prev_q    <= bus.irq_in;
      pending_q <= pending_d;
      id_q      <= id_d;
      vec_q     <= vec_d;
    end
  end

`ifdef INT_MASK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q <= '1;
    end else if (bus.mask_we) begin
      mask_q <= bus.mask_wdata;
    end
  end
`else
  logic unused_mask;
  assign unused_mask = ^{bus.mask_we, bus.mask_wdata};
  assign mask_q      = '1;
`endif

  assign bus.int_req = (state_q == REQ);
  assign bus.busy    = (state_q == SERVICE);
  assign bus.int_id  = id_q;
  assign bus.int_vec = vec_q;
  assign bus.mask_q  = mask_q;

endmodule
